// File: rtl/adc_filt_pkg.sv
// Shared encodings and defaults for the ADC averaging filter bank.
// Optional overrun detection is enabled by defining ADC_FILT_OVERRUN_EN.
package adc_filt_pkg;

    typedef enum logic {
        MODE_BLOCK = 1'b0,
        MODE_IIR   = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EVAL = 2'd2
    } state_e;

    localparam int unsigned DEF_MAX_LEVEL = 10;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_avg_filter_bank_if.sv
// Sample-stream interface (data, channel, valid/ready) for the ADC filter bank.
interface adc_avg_filter_bank_if
    import adc_filt_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DATA_W = 12
);
    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic [DATA_W-1:0] s_data;
    logic [CH_W-1:0]   s_ch;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, s_ch, s_valid, input s_ready);
    modport slave  (input s_data, s_ch, s_valid, output s_ready);

endinterface

// File: rtl/adc_filt_acc_update.sv
// Combinational accumulator update: block average or exponential IIR step.
module adc_filt_acc_update
    import adc_filt_pkg::*;
#(
    parameter  int unsigned DATA_W    = 12,
    parameter  int unsigned MAX_LEVEL = DEF_MAX_LEVEL,
    localparam int unsigned AW        = DATA_W + MAX_LEVEL,
    localparam int unsigned CW        = MAX_LEVEL + 1
) (
    input  mode_e             mode,
    input  logic [3:0]        level,
    input  logic [DATA_W-1:0] x,
    input  logic [AW-1:0]     acc,
    input  logic [CW-1:0]     cnt,
    output logic [AW-1:0]     acc_nx,
    output logic [CW-1:0]     cnt_nx,
    output logic [DATA_W-1:0] out,
    output logic              done
);

    logic [3:0]         lvl;
    logic [AW-1:0]      sum;
    logic signed [AW:0] diff;
    logic signed [AW:0] step;
    logic signed [AW:0] iir;

    always_comb begin
        lvl  = (32'(level) > MAX_LEVEL) ? 4'(MAX_LEVEL) : level;
        sum  = acc + AW'(x);
        // IIR state is y scaled by 2^MAX_LEVEL; difference kept one bit wider and signed
        diff = $signed({1'b0, x, {MAX_LEVEL{1'b0}}}) - $signed({1'b0, acc});
        step = diff >>> lvl;
        iir  = $signed({1'b0, acc}) + step;

        acc_nx = sum;
        cnt_nx = cnt + CW'(1);
        out    = DATA_W'(sum >> lvl);
        done   = (cnt_nx == (CW'(1) << lvl));

        if (mode == MODE_IIR) begin
            acc_nx = AW'(iir);
            cnt_nx = cnt;
            out    = DATA_W'(acc_nx >> MAX_LEVEL);
            done   = 1'b1;
        end
    end

endmodule

// File: rtl/adc_avg_filter_bank.sv
// Multi-channel ADC averaging filter (block average / exponential IIR) with 3-cycle update.
// Define ADC_FILT_OVERRUN_EN to build the sticky overrun detector on m_overrun.
module adc_avg_filter_bank
    import adc_filt_pkg::*;
#(
    parameter  int unsigned NUM_CH    = 8,
    parameter  int unsigned DATA_W    = 12,
    parameter  int unsigned MAX_LEVEL = DEF_MAX_LEVEL,
    localparam int unsigned CH_W      = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     core_en,
    input  logic                     mode,
    input  logic [3:0]               filter_level,
    adc_avg_filter_bank_if.slave     s_if,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic                     m_valid,
    output logic [CH_W-1:0]          m_ch,
    output logic                     m_overrun
);

    localparam int unsigned AW = DATA_W + MAX_LEVEL;
    localparam int unsigned CW = MAX_LEVEL + 1;

    state_e state_q, state_d;

    logic [AW-1:0]     acc_mem [NUM_CH];
    logic [CW-1:0]     cnt_mem [NUM_CH];

    logic [DATA_W-1:0] x_q;
    logic [CH_W-1:0]   ch_q;
    logic [AW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] out_q;
    logic              done_q;
    logic              abort_q;
    mode_e             mode_q;
    logic [3:0]        level_q;

    logic [AW-1:0]     acc_nx;
    logic [CW-1:0]     cnt_nx;
    logic [DATA_W-1:0] out_nx;
    logic              done_nx;

    logic take;
    logic ch_ok;
    logic cfg_change;

    assign take       = s_if.s_valid && s_if.s_ready;
    assign ch_ok      = 32'(s_if.s_ch) < NUM_CH;
    assign cfg_change = (mode != mode_q) || (filter_level != level_q);

    adc_filt_acc_update #(
        .DATA_W    (DATA_W),
        .MAX_LEVEL (MAX_LEVEL)
    ) u_update (
        .mode   (mode_q),
        .level  (level_q),
        .x      (x_q),
        .acc    (acc_q),
        .cnt    (cnt_q),
        .acc_nx (acc_nx),
        .cnt_nx (cnt_nx),
        .out    (out_nx),
        .done   (done_nx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = ST_IDLE;
        s_if.s_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_if.s_ready = reset_n && core_en;
                // an out-of-range channel is consumed but leaves the FSM in IDLE
                state_d = (take && ch_ok) ? ST_ACC : ST_IDLE;
            end
            ST_ACC:  state_d = ST_EVAL;
            ST_EVAL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_mem[i] <= '0;
                cnt_mem[i] <= '0;
            end
            x_q     <= '0;
            ch_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            mode_q  <= MODE_BLOCK;
            level_q <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_ch    <= '0;
        end else begin
            m_valid <= 1'b0;
            mode_q  <= mode_e'(mode);
            level_q <= filter_level;

            case (state_q)
                ST_IDLE: begin
                    if (take && ch_ok) begin
                        x_q   <= s_if.s_data;
                        ch_q  <= s_if.s_ch;
                        acc_q <= cfg_change ? '0 : acc_mem[s_if.s_ch];
                        cnt_q <= cfg_change ? '0 : cnt_mem[s_if.s_ch];
                    end
                end
                ST_ACC: begin
                    acc_mem[ch_q] <= acc_nx;
                    cnt_mem[ch_q] <= cnt_nx;
                    out_q         <= out_nx;
                    done_q        <= done_nx;
                    abort_q       <= cfg_change;
                end
                ST_EVAL: begin
                    if (done_q && mode_q == MODE_BLOCK) begin
                        acc_mem[ch_q] <= '0;
                        cnt_mem[ch_q] <= '0;
                    end
                    if (done_q && !abort_q && !cfg_change) begin
                        m_data[ch_q*DATA_W +: DATA_W] <= out_q;
                        m_valid                       <= 1'b1;
                        m_ch                          <= ch_q;
                    end
                end
                default: ;
            endcase

            // configuration change or idle-disable overrides any per-channel write above
            if (cfg_change || (state_q == ST_IDLE && !core_en)) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    acc_mem[i] <= '0;
                    cnt_mem[i] <= '0;
                end
            end
        end
    end

`ifdef ADC_FILT_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (!reset_n || !core_en)                m_overrun <= 1'b0;
        else if (s_if.s_valid && !s_if.s_ready)  m_overrun <= 1'b1;
    end
`else
    assign m_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_adc_avg_filter_bank.sv
// Directed self-checking bench for adc_avg_filter_bank (NUM_CH=6, DATA_W=12, MAX_LEVEL=10).
module tb_adc_avg_filter_bank;

    localparam int unsigned NCH = 6;
    localparam int unsigned DW  = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          core_en;
    logic          mode;
    logic [3:0]    filter_level;
    logic [NCH*DW-1:0] m_data;
    logic          m_valid;
    logic [2:0]    m_ch;
    logic          m_overrun;

    int checks = 0;
    int passed = 0;

    adc_avg_filter_bank_if #(.NUM_CH(NCH), .DATA_W(DW)) s_if ();

    adc_avg_filter_bank #(
        .NUM_CH    (NCH),
        .DATA_W    (DW),
        .MAX_LEVEL (10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .core_en      (core_en),
        .mode         (mode),
        .filter_level (filter_level),
        .s_if         (s_if),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ch         (m_ch),
        .m_overrun    (m_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (s_if.s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 128'(s_if.s_ready), 128'(1));
    endtask

    // One transfer, then watch four edges for m_valid pulses.
    task automatic xfer(input logic [2:0] ch, input logic [DW-1:0] d,
                        output int pulses, output int lat,
                        output logic [DW-1:0] od, output logic [2:0] och);
        @(negedge clk);
        s_if.s_data  = d;
        s_if.s_ch    = ch;
        s_if.s_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 s_if.s_valid = 1'b0;
        pulses = 0;
        lat    = -1;
        od     = '0;
        och    = '0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (m_valid === 1'b1) begin
                pulses++;
                if (lat < 0) lat = k;
                od  = m_data[m_ch*DW +: DW];
                och = m_ch;
            end
        end
    endtask

    task automatic set_cfg(input logic md, input logic [3:0] lv);
        @(negedge clk);
        mode         = md;
        filter_level = lv;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int pulses, lat, acc_pulses;
        logic [DW-1:0] od;
        logic [2:0] och;
        logic [NCH*DW-1:0] exp_data;
        logic ov_exp;

`ifdef ADC_FILT_OVERRUN_EN
        ov_exp = 1'b1;
`else
        ov_exp = 1'b0;
`endif
        exp_data     = '0;
        reset_n      = 1'b0;
        core_en      = 1'b0;
        mode         = 1'b0;
        filter_level = 4'd0;
        s_if.s_data  = '0;
        s_if.s_ch    = '0;
        s_if.s_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid",   128'(m_valid),      128'(0));
        chk("rst_m_data",    128'(m_data),       128'(0));
        chk("rst_m_ch",      128'(m_ch),         128'(0));
        chk("rst_m_overrun", 128'(m_overrun),    128'(0));
        chk("rst_s_ready",   128'(s_if.s_ready), 128'(0));
        reset_n = 1'b1;
        core_en = 1'b1;
        repeat (2) @(negedge clk);

        // L=0 pass-through, block then IIR
        xfer(3'd0, 12'd4095, pulses, lat, od, och);
        chk("l0_blk_pulses", 128'(pulses), 128'(1));
        chk("l0_blk_lat",    128'(lat),    128'(2));
        chk("l0_blk_data",   128'(od),     128'(4095));
        set_cfg(1'b1, 4'd0);
        xfer(3'd0, 12'd4095, pulses, lat, od, och);
        chk("l0_iir_pulses", 128'(pulses), 128'(1));
        chk("l0_iir_lat",    128'(lat),    128'(2));
        chk("l0_iir_data",   128'(od),     128'(4095));
        xfer(3'd0, 12'd17, pulses, lat, od, och);
        chk("l0_iir_data2",  128'(od),     128'(17));
        exp_data[0*DW +: DW] = 12'd17;

        // block L=2 on ch3: 100,200,300,400 -> 250
        set_cfg(1'b0, 4'd2);
        acc_pulses = 0;
        xfer(3'd3, 12'd100, pulses, lat, od, och); acc_pulses += pulses;
        xfer(3'd3, 12'd200, pulses, lat, od, och); acc_pulses += pulses;
        xfer(3'd3, 12'd300, pulses, lat, od, och); acc_pulses += pulses;
        chk("blk_no_early", 128'(acc_pulses), 128'(0));
        xfer(3'd3, 12'd400, pulses, lat, od, och);
        chk("blk_pulses", 128'(pulses), 128'(1));
        chk("blk_ch",     128'(och),    128'(3));
        chk("blk_data",   128'(od),     128'(250));
        exp_data[3*DW +: DW] = 12'd250;

        // IIR L=1 on ch1: 1000,1000 -> 500, 750
        set_cfg(1'b1, 4'd1);
        xfer(3'd1, 12'd1000, pulses, lat, od, och);
        chk("iir_y1", 128'(od), 128'(500));
        xfer(3'd1, 12'd1000, pulses, lat, od, och);
        chk("iir_y2", 128'(od), 128'(750));
        chk("iir_ch", 128'(och), 128'(1));
        exp_data[1*DW +: DW] = 12'd750;

        // partial block sum on ch5 discarded by a level change
        set_cfg(1'b0, 4'd2);
        acc_pulses = 0;
        xfer(3'd5, 12'd1000, pulses, lat, od, och); acc_pulses += pulses;
        xfer(3'd5, 12'd1000, pulses, lat, od, och); acc_pulses += pulses;
        set_cfg(1'b0, 4'd3);
        for (int i = 0; i < 7; i++) begin
            xfer(3'd5, 12'd8, pulses, lat, od, och);
            acc_pulses += pulses;
        end
        chk("lvlchg_no_early", 128'(acc_pulses), 128'(0));
        xfer(3'd5, 12'd8, pulses, lat, od, och);
        chk("lvlchg_pulses", 128'(pulses), 128'(1));
        chk("lvlchg_data",   128'(od),     128'(8));
        exp_data[5*DW +: DW] = 12'd8;

        // out-of-range channel dropped
        xfer(3'd7, 12'd123, pulses, lat, od, och);
        chk("drop_pulses", 128'(pulses), 128'(0));
        @(negedge clk);
        chk("drop_ready",  128'(s_if.s_ready), 128'(1));
        chk("drop_m_data", 128'(m_data),       128'(exp_data));

        // s_valid held while busy -> overrun (only when detection is built)
        @(negedge clk);
        s_if.s_data  = 12'd5;
        s_if.s_ch    = 3'd2;
        s_if.s_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(posedge clk);
        #1 s_if.s_valid = 1'b0;
        @(negedge clk);
        chk("overrun_set", 128'(m_overrun), 128'(ov_exp));
        repeat (3) @(negedge clk);
        chk("overrun_sticky", 128'(m_overrun), 128'(ov_exp));
        core_en = 1'b0;
        @(negedge clk);
        chk("overrun_clr", 128'(m_overrun), 128'(0));
        core_en = 1'b1;

        // reset during ACC aborts the sample
        set_cfg(1'b0, 4'd0);
        @(negedge clk);
        s_if.s_data  = 12'd77;
        s_if.s_ch    = 3'd3;
        s_if.s_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        s_if.s_valid = 1'b0;
        reset_n      = 1'b0;
        @(posedge clk);
        #1;
        chk("rstacc_m_valid",   128'(m_valid),      128'(0));
        chk("rstacc_m_data",    128'(m_data),       128'(0));
        chk("rstacc_m_ch",      128'(m_ch),         128'(0));
        chk("rstacc_m_overrun", 128'(m_overrun),    128'(0));
        chk("rstacc_s_ready",   128'(s_if.s_ready), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        acc_pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (m_valid === 1'b1) acc_pulses++;
        end
        chk("rstacc_no_pulse", 128'(acc_pulses), 128'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
